// File: rtl/joystick_reader.sv
// joystick_reader: serial game-controller reader producing a registered, signed per-channel snapshot
//
// Drives latch/pulse to a shift-register game controller and shifts in NUM_CH
// two's-complement channels of CH_W bits each. Channel 0 arrives first, and
// each channel arrives MSB first. The completed frame is published as a
// registered snapshot together with a one-cycle valid strobe. Frames are
// separated by POLL_GAP idle cycles.
//
// Optional feature: define JOYSTICK_DEADZONE_EN to force any channel whose
// value lies within [-DEADZONE, DEADZONE] to zero before it is stored.
//
// Ports:
//   i_clk       system clock
//   i_reset     asynchronous active-high reset
//   i_enable    permits a new frame to start (sampled only in IDLE)
//   i_data_in   serial controller data, asynchronous to i_clk
//   o_latch     controller parallel-load strobe
//   o_pulse     controller shift clock
//   o_positions channel k at [k*CH_W +: CH_W], signed
//   o_dir_pos   bit k set when channel k > 0
//   o_dir_neg   bit k set when channel k < 0
//   o_valid     one-cycle strobe while the snapshot is fresh (DONE state)
//   o_busy      high from LATCH through DONE
module joystick_reader #(
    parameter int NUM_CH      = 2,
    parameter int CH_W        = 8,
    parameter int HALF_PERIOD = 250,
    parameter int POLL_GAP    = 50000,
    parameter int DEADZONE    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_data_in,
    output logic                     o_latch,
    output logic                     o_pulse,
    output logic [NUM_CH*CH_W-1:0]   o_positions,
    output logic [NUM_CH-1:0]        o_dir_pos,
    output logic [NUM_CH-1:0]        o_dir_neg,
    output logic                     o_valid,
    output logic                     o_busy
);
    localparam int NB      = NUM_CH * CH_W;
    localparam int CNT_MAX = (2 * HALF_PERIOD > POLL_GAP) ? 2 * HALF_PERIOD : POLL_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NB + 1);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE, S_GAP} state_t;

    if (CH_W < 2 || HALF_PERIOD < 4 || POLL_GAP < 1 || DEADZONE < 0) begin : g_bad_param
        $error("joystick_reader: illegal parameter value");
    end

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_sync;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_lim;
    logic               w_last;
    logic [IDX_W-1:0]   r_idx;
    logic               w_idx_last;
    logic [NB-1:0]      r_shift;
    logic [NB-1:0]      r_pos;
    logic [NUM_CH-1:0]  r_dir_pos;
    logic [NUM_CH-1:0]  r_dir_neg;
    logic [NB-1:0]      w_pos;
    logic [NUM_CH-1:0]  w_dir_pos;
    logic [NUM_CH-1:0]  w_dir_neg;

    // Terminal count of the current phase; IDLE and DONE ignore it.
    assign w_lim = (r_state == S_LATCH) ? CNT_W'(2 * HALF_PERIOD - 1) :
                   (r_state == S_GAP)   ? CNT_W'(POLL_GAP - 1) :
                                          CNT_W'(HALF_PERIOD - 1);
    assign w_last     = (r_cnt == w_lim);
    assign w_idx_last = (r_idx == IDX_W'(NB - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_enable ? S_LATCH : S_IDLE;
            S_LATCH: w_next = w_last ? S_LOW : S_LATCH;
            S_LOW:   w_next = w_last ? S_HIGH : S_LOW;
            S_HIGH:  w_next = w_last ? (w_idx_last ? S_DONE : S_LOW) : S_HIGH;
            S_DONE:  w_next = S_GAP;
            S_GAP:   w_next = w_last ? S_IDLE : S_GAP;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decode directly from the state register, so the asynchronous
    // reset forces latch/pulse low immediately.
    always_comb begin
        o_latch = (r_state == S_LATCH);
        o_pulse = (r_state == S_HIGH);
        o_valid = (r_state == S_DONE);
        o_busy  = (r_state == S_LATCH) || (r_state == S_LOW) ||
                  (r_state == S_HIGH)  || (r_state == S_DONE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_pos     <= '0;
            r_dir_pos <= '0;
            r_dir_neg <= '0;
        end else begin
            r_sync <= {r_sync[0], i_data_in};
            r_cnt  <= (w_last || r_state == S_IDLE || r_state == S_DONE) ? '0 : r_cnt + 1'b1;
            if (r_state == S_LATCH)
                r_idx <= '0;
            else if (r_state == S_HIGH && w_last)
                r_idx <= r_idx + 1'b1;
            // Sample on the final LOW cycle, just before the controller's shift edge.
            if (r_state == S_LOW && w_last)
                r_shift <= {r_shift[NB-2:0], r_sync[1]};
            // Snapshot loads on the edge entering DONE, together with valid.
            if (w_next == S_DONE) begin
                r_pos     <= w_pos;
                r_dir_pos <= w_dir_pos;
                r_dir_neg <= w_dir_neg;
            end
        end
    end

    // Channel 0 was shifted in first, so it sits in the top slice of r_shift.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [CH_W-1:0] w_raw;
        logic signed [CH_W-1:0] w_val;
        assign w_raw = r_shift[(NUM_CH-1-k)*CH_W +: CH_W];
`ifdef JOYSTICK_DEADZONE_EN
        assign w_val = (int'(w_raw) >= -DEADZONE && int'(w_raw) <= DEADZONE) ? '0 : w_raw;
`else
        assign w_val = w_raw;
`endif
        assign w_pos[k*CH_W +: CH_W] = w_val;
        assign w_dir_pos[k] = !w_val[CH_W-1] && (|w_val);
        assign w_dir_neg[k] = w_val[CH_W-1];
    end

    assign o_positions = r_pos;
    assign o_dir_pos   = r_dir_pos;
    assign o_dir_neg   = r_dir_neg;
endmodule

// File: doc/joystick_reader.md
# joystick_reader

Parametrised serial game-controller reader: drives `latch`/`pulse` to a shift-register controller, shifts in `NUM_CH` signed channels of `CH_W` bits each, and publishes them as a registered snapshot with a one-cycle `valid` strobe.
- Adds the following: configurable channel count and width, programmable pulse timing, a poll gap, per-axis direction flags and an optional dead zone.
- Sits between the GPIO pins and the game-logic input layer, alongside the LED/HEX debug displays.

## Interface
Parameters:
- `NUM_CH`, default 2: number of channels (axes).
- `CH_W`, default 8: bits per channel, two's complement; must be ≥ 2.
- `HALF_PERIOD`, default 250: clock cycles per half pulse period; must be ≥ 4.
- `POLL_GAP`, default 50000: idle cycles between frames; must be ≥ 1.
- `DEADZONE`, default 4: dead-zone magnitude; used only when the macro below is defined.

Ports:
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: permits new frames to start.
- `data_in` in 1: serial data from the controller; asynchronous to `clk`.
- `latch` out 1: controller parallel-load strobe.
- `pulse` out 1: controller shift clock.
- `positions` out `NUM_CH*CH_W`: channel k occupies `[k*CH_W +: CH_W]`, signed.
- `dir_pos` out `NUM_CH`: bit k is 1 when channel k is > 0.
- `dir_neg` out `NUM_CH`: bit k is 1 when channel k is < 0.
- `valid` out 1: one-cycle strobe on each snapshot update.
- `busy` out 1: high from the LATCH state through the DONE state.

## Operation
- `data_in` passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE, GAP.
- IDLE: outputs `latch`=0 and `pulse`=0. If `enable`=1, go to LATCH next cycle.
- LATCH: `latch`=1 for `2*HALF_PERIOD` cycles, then go to LOW with bit index 0.
- LOW: `pulse`=0 for `HALF_PERIOD` cycles. On the final LOW cycle, sample the synchronised `data_in` into the shift register, then go to HIGH.
- HIGH: `pulse`=1 for `HALF_PERIOD` cycles, then increment the bit index.
  - If index = `NUM_CH*CH_W`, go to DONE.
  - Otherwise go to LOW.
- Bit order: channel 0 first, MSB first within each channel.
- DONE: lasts one cycle and asserts `valid`.
  - `positions`, `dir_pos` and `dir_neg` update from the shift register on the same edge that raises `valid`.
  - Then go to GAP.
- GAP: waits `POLL_GAP` cycles, then goes to IDLE, which restarts immediately if `enable`=1.
- `enable` is sampled only in IDLE. Deasserting it mid-frame lets the current frame complete normally.
- The shift register is internal. `positions` changes only in DONE, so no partial frame is ever visible.
- Direction flags are a signed compare against 0, applied after any dead-zone processing.

## Timing
- Frame length from the LATCH entry cycle through DONE: `2*HALF_PERIOD*(1 + NUM_CH*CH_W) + 1` cycles.
- Frame period with `enable` held high: frame length + `POLL_GAP` + 1 (the IDLE cycle).
- `data_in` must be stable for ≥ 3 cycles before the final LOW cycle. This is guaranteed if the controller changes data on the `pulse` rising edge.
- Reset values: `latch`=0, `pulse`=0, `valid`=0, `busy`=0, `positions`=0, `dir_pos`=0, `dir_neg`=0, state=IDLE, counters=0.
- Reset asserted mid-frame: `latch` and `pulse` go low asynchronously and the snapshot clears to 0. After release, the first frame starts one cycle after leaving IDLE.
- `-2^(CH_W-1)` is a legal value: `dir_neg`=1, no overflow.

## Configuration
- Macro: `JOYSTICK_DEADZONE_EN`.
- Defined: in DONE, any channel with `-DEADZONE ≤ value ≤ DEADZONE` (signed compare, no abs) is stored as 0, and its `dir_pos` and `dir_neg` bits are 0.
- Undefined: raw values are stored. The `DEADZONE` parameter is ignored and no comparators are built.

## Test plan
All scenarios use `NUM_CH`=2, `CH_W`=8, `HALF_PERIOD`=4, `POLL_GAP`=10.
- Reset then `enable`=1, model shifts ch0=0x05 and ch1=0xF0:
  - `latch` is high for 8 cycles, then 16 `pulse` highs of 4 cycles each.
  - `valid` pulses once, 137 cycles after LATCH entry.
  - `positions`=0xF005, `dir_pos`=01, `dir_neg`=10.
- Same stimulus with `JOYSTICK_DEADZONE_EN` defined and `DEADZONE`=4:
  - ch0=0x05 is reported as 0x05 (5 > 4).
  - Changing ch0 to 0x04 gives `positions[7:0]`=0 and `dir_pos[0]`=0.
  - ch0=0xFC (−4) gives 0.
- ch0=0x80 and ch1=0x7F: `positions`=0x7F80, `dir_neg`=01, `dir_pos`=10.
- Continuous `enable`: consecutive `valid` strobes are exactly 148 cycles apart. Dropping `enable` mid-frame yields exactly one more `valid`, then `latch` stays low.
- `reset` pulsed during the 5th `pulse` high: `latch`, `pulse` and `positions` are 0 immediately, and no `valid` occurs before a full new frame.
- `data_in` toggled 1 cycle before the sample cycle: the sampled bit is the old value, confirming 2-cycle synchroniser latency.
